// File: rtl/data_memory.sv
// ---------------------------------------------------------------------------
// data_memory
//   Responder end of the core's data memory interface. Loads are answered
//   combinationally in the same cycle as the address. Stores commit on the
//   rising clock edge. The address space holds a word-addressed RAM at
//   address 0 and a small register block at MMIO_BASE_P:
//     +0  GPIO    read/write output register
//     +4  COUNT   free-running cycle counter, any write clears it
//     +8  STATUS  {31'b0, bus_error}, writing bit0=1 clears bus_error
//   A store to an unmapped or misaligned address changes nothing and sets
//   the sticky bus-error flag. Loads never have side effects.
//
// Ports
//   clk            clock
//   reset          synchronous, active-low reset
//   i_mem_wr_en    store strobe, one word per cycle
//   i_mem_addr     byte address from the core
//   i_mem_wr_data  store data
//   o_mem_rd_data  load data, combinational from i_mem_addr (0 in reset)
//   o_gpio         GPIO output register
//   o_bus_error    sticky bus-error flag
// ---------------------------------------------------------------------------
module data_memory #(
    parameter int unsigned DATA_WIDTH_P      = 32,
    parameter int unsigned DATA_ADDR_WIDTH_P = 32,
    parameter int unsigned MEM_ADDR_WIDTH_P  = 8,
    parameter logic [DATA_ADDR_WIDTH_P-1:0] MMIO_BASE_P = 32'hFFFF_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_mem_wr_en,
    input  logic [DATA_ADDR_WIDTH_P-1:0] i_mem_addr,
    input  logic [DATA_WIDTH_P-1:0]      i_mem_wr_data,
    output logic [DATA_WIDTH_P-1:0]      o_mem_rd_data,
    output logic [DATA_WIDTH_P-1:0]      o_gpio,
    output logic                         o_bus_error
);

    localparam int unsigned RAM_DEPTH_LP = 1 << MEM_ADDR_WIDTH_P;

    // One extra bit so the RAM byte limit never overflows the address width.
    localparam logic [DATA_ADDR_WIDTH_P:0] RAM_LIMIT_LP =
        (DATA_ADDR_WIDTH_P+1)'(1) << (MEM_ADDR_WIDTH_P + 2);

    localparam logic [DATA_ADDR_WIDTH_P-1:0] GPIO_ADDR_LP   = MMIO_BASE_P;
    localparam logic [DATA_ADDR_WIDTH_P-1:0] COUNT_ADDR_LP  = MMIO_BASE_P + DATA_ADDR_WIDTH_P'(4);
    localparam logic [DATA_ADDR_WIDTH_P-1:0] STATUS_ADDR_LP = MMIO_BASE_P + DATA_ADDR_WIDTH_P'(8);

    logic [DATA_WIDTH_P-1:0] mem_q [RAM_DEPTH_LP];

    logic [DATA_WIDTH_P-1:0] gpio_q,  gpio_d;
    logic [DATA_WIDTH_P-1:0] count_q, count_d;
    logic                    err_q,   err_d;

    logic                        aligned;
    logic                        ram_sel;
    logic                        gpio_sel;
    logic                        count_sel;
    logic                        status_sel;
    logic                        mapped;
    logic                        wr_ok;
    logic [MEM_ADDR_WIDTH_P-1:0] ram_idx;
    logic [DATA_WIDTH_P-1:0]     rd_data;

    // Address decode. Every region requires word alignment.
    always_comb begin
        aligned    = (i_mem_addr[1:0] == 2'b00);
        ram_sel    = aligned && ({1'b0, i_mem_addr} < RAM_LIMIT_LP);
        gpio_sel   = aligned && (i_mem_addr == GPIO_ADDR_LP);
        count_sel  = aligned && (i_mem_addr == COUNT_ADDR_LP);
        status_sel = aligned && (i_mem_addr == STATUS_ADDR_LP);
        mapped     = ram_sel || gpio_sel || count_sel || status_sel;
        ram_idx    = i_mem_addr[MEM_ADDR_WIDTH_P+1:2];
    end

    // A store presented while reset is asserted is dropped entirely.
    assign wr_ok = i_mem_wr_en && reset;

    // Load mux. The same-cycle read of a RAM word being written returns the
    // old contents because mem_q only changes after the edge.
    always_comb begin
        rd_data = '0;
        if (ram_sel) begin
            rd_data = mem_q[ram_idx];
        end else if (gpio_sel) begin
            rd_data = gpio_q;
        end else if (count_sel) begin
            rd_data = count_q;
        end else if (status_sel) begin
            rd_data = {{(DATA_WIDTH_P-1){1'b0}}, err_q};
        end
    end

    assign o_mem_rd_data = reset ? rd_data : '0;
    assign o_gpio        = gpio_q;
    assign o_bus_error   = err_q;

    // Register next-state. The counter clear wins over the increment.
    always_comb begin
        gpio_d  = gpio_q;
        count_d = count_q + DATA_WIDTH_P'(1);
        err_d   = err_q;
        if (i_mem_wr_en) begin
            if (gpio_sel) begin
                gpio_d = i_mem_wr_data;
            end
            if (count_sel) begin
                count_d = '0;
            end
            if (status_sel && i_mem_wr_data[0]) begin
                err_d = 1'b0;
            end
            if (!mapped) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            gpio_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            gpio_q  <= gpio_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // RAM storage carries no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (wr_ok && ram_sel) begin
            mem_q[ram_idx] <= i_mem_wr_data;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

    logic        clk;
    logic        reset;
    logic        i_mem_wr_en;
    logic [31:0] i_mem_addr;
    logic [31:0] i_mem_wr_data;
    logic [31:0] o_mem_rd_data;
    logic [31:0] o_gpio;
    logic        o_bus_error;

    int tests_run;
    int tests_failed;

    data_memory dut (
        .clk           (clk),
        .reset         (reset),
        .i_mem_wr_en   (i_mem_wr_en),
        .i_mem_addr    (i_mem_addr),
        .i_mem_wr_data (i_mem_wr_data),
        .o_mem_rd_data (o_mem_rd_data),
        .o_gpio        (o_gpio),
        .o_bus_error   (o_bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change just after a falling edge; checks follow 1 ns later.
    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] data);
        i_mem_wr_en   = we;
        i_mem_addr    = addr;
        i_mem_wr_data = data;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        drive(1'b0, 32'hFFFF_0004, 32'h0);

        // Reset held low
        repeat (3) next_cycle();
        drive(1'b0, 32'hFFFF_0004, 32'h0);
        check("rst_rd_count", o_mem_rd_data, 32'h0);
        check("rst_gpio",     o_gpio,        32'h0);
        check("rst_err",      {31'b0, o_bus_error}, 32'h0);

        // Release: counter starts at 0, +1 per edge
        reset = 1'b1;
        #1;
        check("cnt_release", o_mem_rd_data, 32'd0);
        repeat (10) next_cycle();
        drive(1'b0, 32'hFFFF_0004, 32'h0);
        check("cnt_10", o_mem_rd_data, 32'd10);

        // RAM write / read-after-write
        drive(1'b1, 32'h0000_0010, 32'h1111_1111);
        next_cycle();
        drive(1'b1, 32'h0000_0014, 32'h1234_5678);
        next_cycle();
        drive(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        check("ram_same_cycle_old", o_mem_rd_data, 32'h1111_1111);
        next_cycle();
        drive(1'b0, 32'h0000_0010, 32'h0);
        check("ram_10_new", o_mem_rd_data, 32'hDEAD_BEEF);
        drive(1'b0, 32'h0000_0014, 32'h0);
        check("ram_14_kept", o_mem_rd_data, 32'h1234_5678);

        // GPIO
        drive(1'b1, 32'hFFFF_0000, 32'hA5A5_0001);
        check("gpio_before_edge", o_gpio, 32'h0);
        next_cycle();
        drive(1'b0, 32'hFFFF_0000, 32'h0);
        check("gpio_after_edge", o_gpio, 32'hA5A5_0001);
        check("gpio_readback", o_mem_rd_data, 32'hA5A5_0001);

        // Bus errors: misaligned and out-of-range stores
        drive(1'b1, 32'h0000_0000, 32'hCAFE_F00D);
        next_cycle();
        drive(1'b1, 32'h0000_03FC, 32'h0BAD_F00D);
        next_cycle();
        drive(1'b1, 32'h0000_0402, 32'hFFFF_FFFF);
        check("err_before_edge", {31'b0, o_bus_error}, 32'h0);
        next_cycle();
        drive(1'b1, 32'h0000_0400, 32'hEEEE_EEEE);
        check("err_set_misaligned", {31'b0, o_bus_error}, 32'h1);
        next_cycle();
        drive(1'b0, 32'h0000_0000, 32'h0);
        check("err_sticky", {31'b0, o_bus_error}, 32'h1);
        check("ram_w0_unchanged", o_mem_rd_data, 32'hCAFE_F00D);
        drive(1'b0, 32'h0000_03FC, 32'h0);
        check("ram_wff_unchanged", o_mem_rd_data, 32'h0BAD_F00D);
        drive(1'b0, 32'h0000_0402, 32'h0);
        check("rd_misaligned_zero", o_mem_rd_data, 32'h0);
        drive(1'b0, 32'hFFFF_000C, 32'h0);
        check("rd_unmapped_zero", o_mem_rd_data, 32'h0);
        check("gpio_unchanged_err", o_gpio, 32'hA5A5_0001);
        drive(1'b0, 32'hFFFF_0008, 32'h0);
        check("status_rd_1", o_mem_rd_data, 32'h1);

        // Misaligned STATUS store is an error, not a clear
        drive(1'b1, 32'hFFFF_0009, 32'h1);
        next_cycle();
        drive(1'b1, 32'hFFFF_0008, 32'h0);
        check("err_misaligned_status", {31'b0, o_bus_error}, 32'h1);
        next_cycle();
        drive(1'b0, 32'hFFFF_0008, 32'h0);
        check("err_bit0_zero_keeps", {31'b0, o_bus_error}, 32'h1);
        drive(1'b1, 32'hFFFF_0008, 32'h1);
        next_cycle();
        drive(1'b0, 32'hFFFF_0008, 32'h0);
        check("err_cleared", {31'b0, o_bus_error}, 32'h0);
        check("status_rd_0", o_mem_rd_data, 32'h0);

        // COUNT clear overrides increment
        drive(1'b1, 32'hFFFF_0004, 32'h0001_2345);
        next_cycle();
        drive(1'b0, 32'hFFFF_0004, 32'h0);
        check("cnt_clear_0", o_mem_rd_data, 32'd0);
        next_cycle();
        #1;
        check("cnt_clear_1", o_mem_rd_data, 32'd1);
        next_cycle();
        #1;
        check("cnt_clear_2", o_mem_rd_data, 32'd2);

        // Counter wrap from a preloaded value
        next_cycle();
        force dut.count_q = 32'hFFFF_FFFE;
        #1;
        release dut.count_q;
        #1;
        check("cnt_preload", o_mem_rd_data, 32'hFFFF_FFFE);
        next_cycle();
        #1;
        check("cnt_max", o_mem_rd_data, 32'hFFFF_FFFF);
        next_cycle();
        #1;
        check("cnt_wrap_0", o_mem_rd_data, 32'h0);
        next_cycle();
        #1;
        check("cnt_wrap_1", o_mem_rd_data, 32'h1);

        // Reset mid-operation with a pending GPIO store
        drive(1'b1, 32'h0000_0401, 32'h0);
        next_cycle();
        drive(1'b0, 32'hFFFF_0000, 32'h0);
        check("err_before_reset", {31'b0, o_bus_error}, 32'h1);
        reset = 1'b0;
        drive(1'b1, 32'hFFFF_0000, 32'hFFFF_FFFF);
        check("rd_forced_in_reset", o_mem_rd_data, 32'h0);
        next_cycle();
        reset = 1'b1;
        drive(1'b0, 32'hFFFF_0000, 32'h0);
        check("gpio_write_discarded", o_gpio, 32'h0);
        check("gpio_rd_after_reset", o_mem_rd_data, 32'h0);
        check("err_reset", {31'b0, o_bus_error}, 32'h0);
        drive(1'b0, 32'hFFFF_0004, 32'h0);
        check("cnt_reset", o_mem_rd_data, 32'h0);
        drive(1'b0, 32'h0000_0010, 32'h0);
        check("ram_survives_reset", o_mem_rd_data, 32'hDEAD_BEEF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
